// File: rtl/freq_frame_reader_pkg.sv
// freq_frame_reader_pkg: shared capture states and defaults for the frequency frame reader
package freq_frame_reader_pkg;
   localparam int NBINS_DEF = 512;
   localparam int BIN_AW_DEF = 9;
   localparam int RD_LAT = 2;
   typedef enum logic [2:0] {
      IDLE    = 3'b001,
      CAPTURE = 3'b010,
      DISCARD = 3'b100
   } state_t;
endpackage

// File: rtl/freq_pingpong_ram.sv
// freq_pingpong_ram: simple dual-port byte RAM with registered read data
module freq_pingpong_ram #(
   parameter int AW = 10
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [7:0]    wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [7:0]    rdata
);
   logic [7:0] mem [2**AW];
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end
endmodule

// File: rtl/freq_frame_reader.sv
// freq_frame_reader: captures FFT frames into a ping-pong RAM and publishes only complete frames
module freq_frame_reader
   import freq_frame_reader_pkg::*;
#(
   parameter int NBINS = NBINS_DEF,
   parameter int BIN_AW = BIN_AW_DEF,
   parameter int FRAME_CW = 16
) (
   input  logic                ckaTime,
   input  logic                btnL,
   input  logic                flgFreqSampleValid,
   input  logic [9:0]          addrFreq,
   input  logic [7:0]          byteFreqSample,
   input  logic                holdFrame,
   input  logic                rdEn,
   input  logic [BIN_AW-1:0]   rdAddr,
   output logic                rdValid,
   output logic [7:0]          rdHeight,
   output logic                flgFrameReady,
   output logic [FRAME_CW-1:0] frameCount,
   output logic [FRAME_CW-1:0] dropCount,
   output logic                flgSyncErr
);
   state_t state, state_nxt;
   logic [BIN_AW-1:0] exp_addr, exp_nxt, a;
   logic s, hit, start, we, err, done, swap_req, swap, wr_bank, wr_sel, v1;
   logic [7:0] q;
   assign a = addrFreq[BIN_AW-1:0];
   assign s = flgFreqSampleValid && ({1'b0, addrFreq} < 11'(NBINS));
   assign swap = swap_req && !holdFrame;
   // a swap takes effect for writes in the very cycle it happens
   assign wr_sel = wr_bank ^ swap;
   always_comb begin
      hit = state == CAPTURE && a == exp_addr;
      start = a == '0 && !hit;
      we = s && (hit || start);
      err = s && state == CAPTURE && !hit;
      done = s && hit && a == BIN_AW'(NBINS - 1);
      exp_nxt = we ? a + 1'b1 : exp_addr;
      state_nxt = !s ? state : done ? IDLE : we ? CAPTURE : err ? DISCARD : state;
   end
   always_ff @(posedge ckaTime or posedge btnL) begin
      if (btnL) begin
         state <= IDLE;
         exp_addr <= '0;
         swap_req <= 1'b0;
         wr_bank <= 1'b0;
         flgFrameReady <= 1'b0;
         frameCount <= '0;
         dropCount <= '0;
         flgSyncErr <= 1'b0;
         v1 <= 1'b0;
         rdValid <= 1'b0;
         rdHeight <= '0;
      end else begin
         state <= state_nxt;
         exp_addr <= exp_nxt;
         swap_req <= done;
         wr_bank <= wr_sel;
         flgFrameReady <= swap;
         frameCount <= frameCount + FRAME_CW'(swap);
         dropCount <= dropCount + FRAME_CW'(err);
         flgSyncErr <= flgSyncErr || err;
         v1 <= rdEn;
         rdValid <= v1;
         if (v1) rdHeight <= q;
      end
   end
   freq_pingpong_ram #(.AW(BIN_AW + 1)) ram (
      .clk(ckaTime),
      .we(we),
      .waddr({wr_sel, a}),
      .wdata(byteFreqSample),
      .re(rdEn),
      .raddr({~wr_bank, rdAddr}),
      .rdata(q)
   );
endmodule

// File: tb/tb_freq_frame_reader.sv
// tb_freq_frame_reader: directed frames checked against a frame-level model of freq_frame_reader
module tb_freq_frame_reader;
   import freq_frame_reader_pkg::*;
   localparam int NB = NBINS_DEF;
   logic clk = 1'b0, btnL = 1'b1, valid = 1'b0, hold = 1'b0, rd_en = 1'b0;
   logic [9:0] addr = '0;
   logic [7:0] data = '0;
   logic [BIN_AW_DEF-1:0] rd_addr = '0;
   logic rd_valid, ready, sync_err;
   logic [7:0] height;
   logic [15:0] frame_count, drop_count;
   int checks = 0, failures = 0;
   freq_frame_reader dut (
      .ckaTime(clk), .btnL(btnL), .flgFreqSampleValid(valid), .addrFreq(addr),
      .byteFreqSample(data), .holdFrame(hold), .rdEn(rd_en), .rdAddr(rd_addr),
      .rdValid(rd_valid), .rdHeight(height), .flgFrameReady(ready),
      .frameCount(frame_count), .dropCount(drop_count), .flgSyncErr(sync_err)
   );
   always #5 clk = ~clk;
   task automatic chk(string n, int act, int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
      end
   endtask
   // frame-level model: in-order capture buffer, pending complete frame, published frame
   int nxt = -1, fc = 0, dc = 0, k = 0;
   bit pend = 0, pub_k = 0, last_k = 1, rdy = 0, se = 0, ev = 0;
   logic [7:0] cap [NB], done_f [NB], pub [NB];
   logic [7:0] last_h = '0;
   bit rq_v [4], rq_k [4];
   logic [7:0] rq_d [4];
   always @(posedge clk) begin
      int a, p;
      bit acc;
      p = (k + 5 - RD_LAT) % 4;
      if (btnL) begin
         nxt = -1; pend = 0; fc = 0; dc = 0; se = 0; rdy = 0; pub_k = 0;
         last_h = '0; last_k = 1; ev = 0;
         for (int i = 0; i < 4; i++) rq_v[i] = 0;
      end else begin
         rq_v[k % 4] = rd_en;
         rq_d[k % 4] = pub[rd_addr];
         rq_k[k % 4] = pub_k;
         rdy = pend && !hold;
         if (rdy) begin
            pub = done_f;
            pub_k = 1;
            fc = (fc + 1) % 65536;
         end
         pend = 0;
         if (valid && addr < NB) begin
            a = int'(addr);
            acc = 0;
            if (nxt >= 0 && a == nxt) acc = 1;
            else begin
               if (nxt >= 0) begin se = 1; dc = (dc + 1) % 65536; end
               nxt = -1;
               acc = (a == 0);
            end
            if (acc) begin
               cap[a] = data;
               nxt = a + 1;
               if (a == NB - 1) begin done_f = cap; pend = 1; nxt = -1; end
            end
         end
         ev = rq_v[p];
         if (ev) begin last_h = rq_d[p]; last_k = rq_k[p]; end
      end
      k++;
      #1;
      chk("ready", ready, rdy);
      chk("frame_count", frame_count, fc);
      chk("drop_count", drop_count, dc);
      chk("sync_err", sync_err, se);
      chk("rd_valid", rd_valid, ev);
      if (last_k) chk("rd_height", height, last_h);
   end
   task automatic cyc(bit v, int a, int d, bit re, int ra);
      @(negedge clk);
      valid = v; addr = 10'(a); data = 8'(d); rd_en = re; rd_addr = BIN_AW_DEF'(ra);
   endtask
   task automatic idle(int n);
      repeat (n) cyc(0, 0, 0, 0, 0);
   endtask
   task automatic rd_lit(int ra, int e, string n);
      cyc(0, 0, 0, 1, ra);
      cyc(0, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      chk({n, "_valid"}, rd_valid, 1);
      chk(n, height, e);
   endtask
   task automatic frame(int seed, int skip, bit mirror, int rd_old, int rd_new, int rst_at, int gap);
      for (int i = 0; i < NB; i++) begin
         if (i == skip) continue;
         cyc(1, i, (i + seed) & 255, rd_old >= 0 && i < 2, 5);
         if (i == 2 && rd_old >= 0) chk("swap_rd_old", height, rd_old);
         if (i == 3 && rd_new >= 0) chk("swap_rd_new", height, rd_new);
         if (mirror && i % 50 == 5) cyc(1, NB + i, 8'hAA, 0, 0);
         if (i == rst_at) begin
            #2 btnL = 1'b1;
            #1;
            chk("arst_count", frame_count, 0);
            chk("arst_drop", drop_count, 0);
            chk("arst_err", sync_err, 0);
            chk("arst_valid", rd_valid, 0);
            chk("arst_height", height, 0);
            chk("arst_ready", ready, 0);
            @(negedge clk);
            valid = 1'b0;
            btnL = 1'b0;
            return;
         end
      end
      idle(gap);
   endtask
   initial begin
      repeat (3) @(negedge clk);
      chk("rst_count", frame_count, 0);
      chk("rst_ready", ready, 0);
      chk("rst_valid", rd_valid, 0);
      chk("rst_err", sync_err, 0);
      btnL = 1'b0;
      idle(2);
      frame(0, -1, 0, -1, -1, -1, 2);
      chk("t1_count", frame_count, 1);
      chk("t1_err", sync_err, 0);
      rd_lit(5, 5, "t1_rd5");
      rd_lit(300, 44, "t1_rd300");
      frame(7, 100, 0, -1, -1, -1, 2);
      chk("t2_err", sync_err, 1);
      chk("t2_drop", drop_count, 1);
      chk("t2_count", frame_count, 1);
      rd_lit(5, 5, "t2_rd5_kept");
      frame(3, -1, 0, -1, -1, -1, 2);
      chk("t2_count_next", frame_count, 2);
      rd_lit(5, 8, "t2_rd5_new");
      frame(20, -1, 1, -1, -1, -1, 2);
      chk("t3_count", frame_count, 3);
      chk("t3_drop", drop_count, 1);
      rd_lit(5, 25, "t3_rd5");
      rd_lit(305, 69, "t3_rd305");
      hold = 1'b1;
      frame(40, -1, 0, -1, -1, -1, 2);
      frame(41, -1, 0, -1, -1, -1, 2);
      chk("t4_count_held", frame_count, 3);
      rd_lit(5, 25, "t4_rd5_held");
      hold = 1'b0;
      frame(50, -1, 0, -1, -1, -1, 2);
      chk("t4_count", frame_count, 4);
      rd_lit(5, 55, "t4_rd5_new");
      frame(60, -1, 0, -1, -1, -1, 0);
      frame(61, -1, 0, 55, 65, -1, 2);
      chk("t5_count", frame_count, 6);
      chk("t5_drop", drop_count, 1);
      rd_lit(5, 66, "t5_rd5");
      frame(70, -1, 0, -1, -1, 250, 0);
      idle(2);
      frame(80, -1, 0, -1, -1, -1, 2);
      chk("t6_count", frame_count, 1);
      chk("t6_drop", drop_count, 0);
      chk("t6_err", sync_err, 0);
      rd_lit(5, 85, "t6_rd5");
      idle(2);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/freq_frame_reader.md
Name: freq_frame_reader

Overview:
- Receiving end of the FFT frequency-sample write stream (valid/address/byte).
- Captures each FFT output frame into a ping-pong buffer and checks that the frame arrived complete and in order.
- Publishes only complete frames to a random-access read port consumed by the display controller, so the display never shows a partially written frame.
- Sits between the FFT block and the image controller, all on the 100 MHz system clock.

Parameters:
- NBINS, 512, number of bins captured per frame (addresses 0..NBINS-1); must be a power of 2 and no larger than 1024.
- BIN_AW, 9, log2(NBINS); width of the read address.
- FRAME_CW, 16, width of the frame counters.

Ports:
- ckaTime  in  1  100 MHz system clock; the only clock.
- btnL  in  1  reset, asynchronous, active-high.
- flgFreqSampleValid  in  1  write strobe from FFT, one sample per high cycle.
- addrFreq  in  10  bin index of the current sample.
- byteFreqSample  in  8  bin height.
- holdFrame  in  1  1 = freeze the published frame (no bank swaps).
- rdEn  in  1  read request.
- rdAddr  in  BIN_AW  bin to read.
- rdValid  out  1  read data valid.
- rdHeight  out  8  bin height from the published bank.
- flgFrameReady  out  1  one-cycle pulse on each bank swap.
- frameCount  out  FRAME_CW  number of frames published.
- dropCount  out  FRAME_CW  number of frames discarded.
- flgSyncErr  out  1  sticky; set on any sequence error.

Behaviour:
- Reset (async on btnL, released synchronously):
  - all outputs 0;
  - wrBank=0, rdBank=1;
  - FSM state IDLE; expected address expAddr=0.
- Input filter: samples with addrFreq >= NBINS (mirror half) are ignored entirely. They are not written, cause no sequence check and trigger no state change.
- Capture FSM, states IDLE / CAPTURE / DISCARD:
  - IDLE:
    - valid sample with addr==0: write it, expAddr<=1, go to CAPTURE.
    - any other in-range valid sample: ignore it and stay in IDLE; this is not an error, it is waiting for frame start.
  - CAPTURE:
    - valid sample with addr==expAddr: write it, expAddr++.
    - If addr==NBINS-1, the frame is complete: go to IDLE and request a swap.
    - valid sample with addr!=expAddr:
      - set flgSyncErr, dropCount++;
      - if addr==0, restart the capture in place: write it, expAddr<=1, stay in CAPTURE;
      - otherwise go to DISCARD.
  - DISCARD: wait for a valid sample with addr==0, then behave as in IDLE.
- Write port: writes go to bank wrBank only, at address {wrBank, addrFreq[BIN_AW-1:0]}, one write per accepted sample, in the same cycle it is accepted.
- Swap, evaluated in the cycle after a complete frame is detected:
  - If holdFrame=0: exchange wrBank and rdBank, pulse flgFrameReady for 1 cycle, frameCount++ (wraps at 2^FRAME_CW).
  - If holdFrame=1: no swap; the completed frame is overwritten by the next capture, and frameCount/dropCount are unchanged.
- Read port:
  - Fixed latency of 2 cycles: a request with rdEn=1 in cycle t gives rdValid=1 and rdHeight in cycle t+2.
  - Fully pipelined, so one request per cycle is accepted.
  - rdBank is sampled in the request cycle. A request made in the swap cycle returns old-bank data; requests from t+1 onward see the new bank.
  - rdHeight holds its last value when rdValid=0.
- Counters saturate-free: both counters wrap.
- Simultaneous events:
  - a frame-complete swap and a new addr==0 write in the following cycle: the new write goes to the new wrBank, because the swap has priority in that cycle.
  - If the FFT delivers back-to-back frames with zero gap, no sample is lost.
- Reset mid-frame: the partial frame is lost, and the read data after reset is from bank 1 (contents undefined until the first swap).
- Storage: a single simple dual-port RAM of 2*NBINS x 8, inferred; one write port and one registered read port, plus an output register.

Decomposition:
- Shared package contains:
  - FSM state encodings (one-hot, 3 bits);
  - NBINS / BIN_AW defaults;
  - the read latency constant RD_LAT=2.
- One sub-module: freq_pingpong_ram, a generic 2*NBINS x 8 simple dual-port RAM with registered output; bank selection is done by the address MSB in the parent.

Test Plan:
1. Reset, then one clean frame of addresses 0..511 with byte=addr[7:0], holdFrame=0 -> flgFrameReady pulses once, frameCount=1. Reading rdAddr=5 returns rdHeight=5 at t+2, and rdAddr=300 returns 44.
2. Frame with addresses 0..99, then 101..511 (100 skipped) -> flgSyncErr=1, dropCount=1, no swap, frameCount unchanged. The next clean frame publishes and gives frameCount+1.
3. Samples with addresses 512..1023 interleaved in a clean frame -> ignored, no error, the frame publishes normally.
4. holdFrame=1 across two complete frames -> no flgFrameReady pulse and the read data is unchanged. Set holdFrame=0, then one more frame -> swap, and the new data is readable.
5. Back-to-back frames with no gap, with a read issued in the exact swap cycle -> that read returns old-frame data, and reads from the next cycle return new-frame data; no sample is dropped.
6. Assert btnL asynchronously mid-frame (at address 250) -> all outputs 0 immediately. After release, the first frame starting at address 0 publishes correctly, giving frameCount=1.
